// File: rtl/packetizer_pkg.sv
// Shared types and config decoding for the AXI-Stream packetizer.
// The {k,len} config word layout matches packet_add_top.
package packetizer_pkg;

  localparam int CFG_DW = 8;
  localparam int CFG_CW = 2 * CFG_DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2
  } state_t;

  // A zero length field encodes the maximum packet length of 2^DW beats.
  function automatic logic [CFG_DW:0] cfg_len(input logic [CFG_CW-1:0] cfg);
    if (cfg[CFG_DW-1:0] == {CFG_DW{1'b0}}) begin
      cfg_len = {1'b1, {CFG_DW{1'b0}}};
    end else begin
      cfg_len = {1'b0, cfg[CFG_DW-1:0]};
    end
  endfunction

  function automatic logic [CFG_DW-1:0] cfg_k(input logic [CFG_CW-1:0] cfg);
    if (cfg[CFG_CW-1:CFG_DW] == {CFG_DW{1'b0}}) begin
      cfg_k = {{(CFG_DW-1){1'b0}}, 1'b1};
    end else begin
      cfg_k = cfg[CFG_CW-1:CFG_DW];
    end
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer carrying DW data bits plus {user,last} sideband.
// Every output and the upstream ready come straight from flops.
module axis_reg_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW+1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW+1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW+1:0] out_data_q, out_data_d;
  logic [DW+1:0] skid_data_q, skid_data_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          in_fire;

  // Next-state: drain skid first, park incoming beat in skid when stalled.
  always_comb begin
    in_fire      = in_valid && in_ready_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    in_ready_d = !skid_valid_d;
  end

  // State flops; ready stays low for the whole reset assertion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= {(DW+2){1'b0}};
      skid_valid_q <= 1'b0;
      skid_data_q  <= {(DW+2){1'b0}};
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/axis_packetizer.sv
// Cuts a byte stream into fixed-length packets, zero-pads early ends and
// flags every k-th packet end on m_tuser.
module axis_packetizer
  import packetizer_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 2 * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  output logic          m_tuser,
  input  logic          m_tready,
  input  logic [CW-1:0] config_packet,
  output logic          pad_evt,
  output logic [15:0]   pkt_cnt
);

  state_t        state_q, state_d;
  logic [DW:0]   beat_q, beat_d;
  logic [DW:0]   len_l_q, len_l_d;
  logic [DW-1:0] k_l_q, k_l_d;
  logic [DW-1:0] grp_q, grp_d;
  logic          pad_evt_q, pad_evt_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;

  logic [DW:0]   cur_len;
  logic [DW-1:0] cur_k;
  logic          sl_in_valid, sl_in_ready, sl_out_valid;
  logic [DW+1:0] sl_in_data, sl_out_data;
  logic          fire, is_end, user_b;

  // Config is taken live from the port only at packet start (k only at group start).
  always_comb begin
    cur_len     = (state_q == IDLE) ? cfg_len(config_packet) : len_l_q;
    cur_k       = (state_q == IDLE && grp_q == {DW{1'b0}}) ? cfg_k(config_packet) : k_l_q;
    sl_in_valid = (state_q == PAD) ? 1'b1 : s_tvalid;
    fire        = sl_in_valid && sl_in_ready;
    is_end      = (beat_q == (cur_len - {{DW{1'b0}}, 1'b1}));
    user_b      = is_end && (grp_q == (cur_k - {{(DW-1){1'b0}}, 1'b1}));
    sl_in_data  = {user_b, is_end, (state_q == PAD) ? {DW{1'b0}} : s_tdata};

    state_d   = state_q;
    beat_d    = beat_q;
    len_l_d   = len_l_q;
    k_l_d     = k_l_q;
    grp_d     = grp_q;
    pad_evt_d = 1'b0;
    if (fire) begin
      len_l_d = cur_len;
      k_l_d   = cur_k;
      if (is_end) begin
        beat_d  = {(DW+1){1'b0}};
        state_d = IDLE;
        grp_d   = user_b ? {DW{1'b0}} : grp_q + {{(DW-1){1'b0}}, 1'b1};
      end else begin
        beat_d = beat_q + {{DW{1'b0}}, 1'b1};
        case (state_q)
          PAD: state_d = PAD;
          default: begin
            if (s_tlast) begin
              state_d   = PAD;
              pad_evt_d = 1'b1;
            end else begin
              state_d = PASS;
            end
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (m_tvalid && m_tready && m_tlast) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
  end

  // Control state flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= {(DW+1){1'b0}};
      len_l_q   <= {(DW+1){1'b0}};
      k_l_q     <= {DW{1'b0}};
      grp_q     <= {DW{1'b0}};
      pad_evt_q <= 1'b0;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      len_l_q   <= len_l_d;
      k_l_q     <= k_l_d;
      grp_q     <= grp_d;
      pad_evt_q <= pad_evt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  axis_reg_slice #(.DW(DW)) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_data   (sl_in_data),
    .in_valid  (sl_in_valid),
    .in_ready  (sl_in_ready),
    .out_data  (sl_out_data),
    .out_valid (sl_out_valid),
    .out_ready (m_tready)
  );

  assign s_tready = (state_q != PAD) && sl_in_ready;
  assign m_tvalid = sl_out_valid;
  assign {m_tuser, m_tlast, m_tdata} = sl_out_data;
  assign pad_evt  = pad_evt_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule
